// File: rtl/led_frame_controller.sv
// Frame sequencer for a WS2812B bit serializer: fetches NUM_PIXELS GRB words from a
// synchronous frame buffer, streams them MSB-first, then holds the line low for the latch gap.
module led_frame_controller #(
   parameter int NUM_PIXELS   = 64,
   parameter int ADDR_W       = 6,
   parameter int BIT_CYCLES   = 15,
   parameter int RESET_CYCLES = 4000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [23:0]       mem_data,
   input  logic              shift,
   output logic              serial_out,
   output logic              transmit_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_TAIL  = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;

   localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int TAIL_W = $clog2(BIT_CYCLES);
   localparam int LAT_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIXELS - 1);
   localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(BIT_CYCLES - 3);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RESET_CYCLES - 1);
   localparam bit                MULTI_PIX = (NUM_PIXELS > 1);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [23:0]       active_reg;
   logic [23:0]       next_reg;
   logic [4:0]        bit_ptr;
   logic [PIX_W-1:0]  pix_idx;
   logic [TAIL_W-1:0] tail_cnt;
   logic [LAT_W-1:0]  latch_cnt;
   logic              pending;
   logic              load_next;
   logic              issue_next;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_issue;
   logic              last_bit;
   logic              last_pix;
   logic              latch_end;
   logic              restart;

   assign last_bit  = (bit_ptr == 5'd23);
   assign last_pix  = (pix_idx == LAST_PIX);
   assign latch_end = (state == S_LATCH) && (latch_cnt == LAT_LAST);
   // A start arriving in the done cycle is folded into the restart decision.
   assign restart   = latch_end && (pending || start);

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_SEND;
         S_SEND:  if (shift && last_bit && last_pix) state_nxt = S_TAIL;
         S_TAIL:  if (tail_cnt == TAIL_LAST) state_nxt = S_LATCH;
         S_LATCH: if (latch_cnt == LAT_LAST) state_nxt = restart ? S_FETCH : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_issue = 1'b0;
      rd_addr  = '0;
      case (state)
         S_IDLE:  rd_issue = start;
         S_FETCH: begin
            rd_issue = MULTI_PIX;
            rd_addr  = ADDR_W'(1);
         end
         S_SEND: begin
            rd_issue = issue_next;
            rd_addr  = ADDR_W'(pix_idx) + ADDR_W'(1);
         end
         S_LATCH: rd_issue = restart;
         default: rd_issue = 1'b0;
      endcase
   end

   assign mem_rd_en = rd_issue;
   assign mem_addr  = rd_issue ? rd_addr : addr_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         bit_ptr    <= '0;
         pix_idx    <= '0;
         tail_cnt   <= '0;
         latch_cnt  <= '0;
         pending    <= 1'b0;
         load_next  <= 1'b0;
         issue_next <= 1'b0;
         addr_q     <= '0;
      end else begin
         state      <= state_nxt;
         addr_q     <= mem_addr;
         issue_next <= 1'b0;
         // Prefetch reads land in next_reg; reads of pixel 0 land in active_reg during FETCH.
         load_next  <= rd_issue && ((state == S_FETCH) || (state == S_SEND));

         if (restart) begin
            pending <= 1'b0;
         end else if (start && (state != S_IDLE)) begin
            pending <= 1'b1;
         end

         case (state)
            S_FETCH: begin
               bit_ptr <= '0;
               pix_idx <= '0;
            end
            S_SEND: begin
               if (shift) begin
                  if (!last_bit) begin
                     bit_ptr <= bit_ptr + 5'd1;
                  end else if (!last_pix) begin
                     bit_ptr    <= '0;
                     pix_idx    <= pix_idx + 1'b1;
                     issue_next <= (int'(pix_idx) + 2) < NUM_PIXELS;
                  end else begin
                     tail_cnt <= '0;
                  end
               end
            end
            S_TAIL: begin
               tail_cnt <= tail_cnt + 1'b1;
               if (tail_cnt == TAIL_LAST) latch_cnt <= '0;
            end
            S_LATCH: latch_cnt <= latch_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: pixel registers are pure datapath and are never read before being loaded, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state == S_FETCH) begin
         active_reg <= mem_data;
      end else if ((state == S_SEND) && shift && last_bit && !last_pix) begin
         active_reg <= next_reg;
      end
      if (load_next) next_reg <= mem_data;
   end

   assign busy         = (state != S_IDLE);
   assign done         = latch_end;
   assign transmit_out = (state == S_SEND) || (state == S_TAIL);
   assign serial_out   = (state == S_SEND) && active_reg[5'd23 - bit_ptr];

endmodule

// File: tb/tb_led_frame_controller.sv
// Bench for led_frame_controller: two instances (2 pixels and 1 pixel) each driving a
// behavioural 15-clock WS2812B serializer whose decoded output is compared against the RAM words.
module tb_led_frame_controller;

   localparam int BITC    = 15;
   localparam int RST_CYC = 20;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] start = '0;
   logic [1:0] shift_force = '0;
   logic [1:0] busy, done, mem_rd_en, serial_out, transmit_out, shift_dut, ws;
   logic [1:0] mem_addr;
   logic [23:0] mem_data [2] = '{24'h0, 24'h0};
   logic [23:0] ram [2][2];

   // serializer model state and monitors
   logic [1:0]  ser_shift = '0;
   logic [1:0]  ser_act   = '0;
   logic [1:0]  ser_bit   = '0;
   logic [1:0]  tx_prev   = '0;
   int          ser_cnt [2] = '{0, 0};
   int          hi_run  [2] = '{0, 0};
   int          tx_cnt  [2] = '{0, 0};
   int          tx_last [2] = '{0, 0};
   int          tx_rise [2] = '{0, 0};
   int          lat_cnt [2] = '{0, 0};
   int          rd_cnt  [2] = '{0, 0};
   int          done_cnt[2] = '{0, 0};
   int          long_cnt[2] = '{0, 0};
   int          short_cnt[2] = '{0, 0};
   int          bad_cnt [2] = '{0, 0};
   logic [63:0] rx_word [2] = '{64'h0, 64'h0};
   int          cyc = 0;

   int s_tx[2], s_lat[2], s_rd[2], s_done[2], s_rise[2], s_long[2], s_short[2], s_bad[2];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign shift_dut = ser_shift | shift_force;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      led_frame_controller #(
         .NUM_PIXELS(2 - g), .ADDR_W(1), .BIT_CYCLES(BITC), .RESET_CYCLES(RST_CYC)
      ) u_dut (
         .clk(clk), .reset(reset), .start(start[g]), .busy(busy[g]), .done(done[g]),
         .mem_addr(mem_addr[g:g]), .mem_rd_en(mem_rd_en[g]), .mem_data(mem_data[g]),
         .shift(shift_dut[g]), .serial_out(serial_out[g]), .transmit_out(transmit_out[g])
      );
   end

   always_comb begin
      ws = '0;
      for (int i = 0; i < 2; i++)
         ws[i] = ser_act[i] && (((ser_cnt[i] == 0) ? BITC - 1 : ser_cnt[i] - 1) < (ser_bit[i] ? 10 : 5));
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (mem_rd_en[i]) begin
            mem_data[i] <= ram[i][mem_addr[i]];
            rd_cnt[i]   <= rd_cnt[i] + 1;
         end
         if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
         if (transmit_out[i]) begin
            tx_cnt[i]  <= tx_cnt[i] + 1;
            tx_last[i] <= cyc;
         end
         if (transmit_out[i] && !tx_prev[i]) tx_rise[i] <= tx_rise[i] + 1;
         tx_prev[i] <= transmit_out[i];
         if (!transmit_out[i]) begin
            ser_cnt[i] <= 0; ser_act[i] <= 1'b0; ser_shift[i] <= 1'b0;
         end else if (ser_cnt[i] == 0) begin
            ser_bit[i]   <= serial_out[i];
            ser_act[i]   <= 1'b1;
            ser_cnt[i]   <= 1;
            ser_shift[i] <= 1'b1;
            lat_cnt[i]   <= lat_cnt[i] + 1;
            rx_word[i]   <= {rx_word[i][62:0], serial_out[i]};
         end else begin
            ser_cnt[i]   <= (ser_cnt[i] == BITC - 1) ? 0 : ser_cnt[i] + 1;
            ser_shift[i] <= 1'b0;
         end
         if (ws[i]) begin
            hi_run[i] <= hi_run[i] + 1;
         end else begin
            if (hi_run[i] == 10)     long_cnt[i]  <= long_cnt[i] + 1;
            else if (hi_run[i] == 5) short_cnt[i] <= short_cnt[i] + 1;
            else if (hi_run[i] != 0) bad_cnt[i]   <= bad_cnt[i] + 1;
            hi_run[i] <= 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic snap(input int i);
      s_tx[i] = tx_cnt[i];     s_lat[i] = lat_cnt[i];    s_rd[i] = rd_cnt[i];
      s_done[i] = done_cnt[i]; s_rise[i] = tx_rise[i];   s_long[i] = long_cnt[i];
      s_short[i] = short_cnt[i]; s_bad[i] = bad_cnt[i];
   endtask

   task automatic pulse_start(input int i);
      @(negedge clk); start[i] = 1'b1;
      @(negedge clk); start[i] = 1'b0;
   endtask

   task automatic start_frame(input int i);
      @(negedge clk); start[i] = 1'b1; #1;
      check("issue_addr0", 64'({mem_rd_en[i], mem_addr[i]}), 64'b10);
      @(negedge clk); start[i] = 1'b0;
      check("fetch_busy", 64'({busy[i], mem_rd_en[i], mem_addr[i]}), (i == 0) ? 64'b111 : 64'b100);
   endtask

   task automatic wait_lat(input int i, input int n);
      for (int k = 0; k < 5000; k++) begin
         if (lat_cnt[i] - s_lat[i] >= n) return;
         @(negedge clk);
      end
      check("wait_lat_timeout", 64'd0, 64'd1);
   endtask

   task automatic finish_frame(input int i, input string tag, input bit again);
      bit seen = 1'b0;
      for (int k = 0; k < 5000 && !seen; k++) begin
         @(negedge clk);
         seen = done[i];
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (!seen) return;
      check({tag, "_latch_gap"}, 64'(cyc - tx_last[i]), 64'(RST_CYC));
      check({tag, "_ser_idle"}, 64'({ser_act[i], serial_out[i], transmit_out[i]}), 64'd0);
      if (again) check({tag, "_refetch"}, 64'({mem_rd_en[i], mem_addr[i]}), 64'b10);
      @(negedge clk);
      check({tag, "_busy_after"}, 64'(busy[i]), 64'(again));
   endtask

   task automatic check_deltas(input int i, input string tag, input int nf, input logic [47:0] bits);
      int          nb;
      logic [63:0] mask;
      nb   = 24 * (2 - i);
      mask = (64'd1 << nb) - 64'd1;
      check({tag, "_tx_cycles"}, 64'(tx_cnt[i] - s_tx[i]), 64'(nf * nb * BITC));
      check({tag, "_shifts"},    64'(lat_cnt[i] - s_lat[i]), 64'(nf * nb));
      check({tag, "_reads"},     64'(rd_cnt[i] - s_rd[i]), 64'(nf * (2 - i)));
      check({tag, "_dones"},     64'(done_cnt[i] - s_done[i]), 64'(nf));
      check({tag, "_tx_rises"},  64'(tx_rise[i] - s_rise[i]), 64'(nf));
      check({tag, "_pulses"},    64'(long_cnt[i] - s_long[i] + short_cnt[i] - s_short[i]), 64'(nf * nb));
      check({tag, "_long"},      64'(long_cnt[i] - s_long[i]), 64'(nf * $countones({16'h0, bits} & mask)));
      check({tag, "_bad_pulse"}, 64'(bad_cnt[i] - s_bad[i]), 64'd0);
      check({tag, "_bits"},      rx_word[i] & mask, {16'h0, bits} & mask);
   endtask

   task automatic full_frame(input int i, input string tag);
      logic [47:0] bits;
      bits = (i == 0) ? {ram[0][0], ram[0][1]} : {24'h0, ram[1][0]};
      snap(i);
      start_frame(i);
      finish_frame(i, tag, 1'b0);
      check_deltas(i, tag, 1, bits);
   endtask

   initial begin
      logic [23:0] w0, w1;
      ram[0][0] = 24'hFF0000; ram[0][1] = 24'h00AA55;
      ram[1][0] = 24'h000001; ram[1][1] = 24'h000000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++)
         check("reset_outputs", 64'({busy[i], done[i], mem_rd_en[i], mem_addr[i], serial_out[i], transmit_out[i]}), 64'd0);

      full_frame(0, "fixed2");
      full_frame(1, "fixed1");

      for (int r = 0; r < 2; r++) begin
         ram[0][0] = 24'($urandom); ram[0][1] = 24'($urandom); ram[1][0] = 24'($urandom);
         full_frame(0, "rand2");
         full_frame(1, "rand1");
      end

      // RAM rewritten after the prefetch must not affect the frame in flight
      w0 = 24'($urandom); w1 = 24'($urandom);
      ram[0][0] = w0; ram[0][1] = w1;
      snap(0);
      start_frame(0);
      wait_lat(0, 3);
      ram[0][0] = ~w0; ram[0][1] = ~w1;
      finish_frame(0, "prefetch", 1'b0);
      check_deltas(0, "prefetch", 1, {w0, w1});
      full_frame(0, "rewritten");

      // two starts while busy give exactly one back-to-back frame
      snap(0);
      start_frame(0);
      wait_lat(0, 5);
      pulse_start(0);
      wait_lat(0, 30);
      pulse_start(0);
      finish_frame(0, "b2b_first", 1'b1);
      finish_frame(0, "b2b_second", 1'b0);
      check_deltas(0, "b2b", 2, {ram[0][0], ram[0][1]});
      repeat (100) @(negedge clk);
      check("b2b_no_third", 64'({done_cnt[0] - s_done[0], busy[0]}), {32'd2, 1'b0});

      // reset at pixel 1 bit 10
      ram[0][0] = 24'($urandom); ram[0][1] = 24'($urandom);
      snap(0);
      start_frame(0);
      wait_lat(0, 35);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("mid_reset_outputs", 64'({busy[0], done[0], mem_rd_en[0], mem_addr[0], serial_out[0], transmit_out[0]}), 64'd0);
      check("mid_reset_no_done", 64'(done_cnt[0] - s_done[0]), 64'd0);
      repeat (5) @(negedge clk);
      full_frame(0, "after_reset");

      // shift while IDLE is ignored; address holds the last pixel read
      shift_force[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("idle_shift", 64'({busy[0], mem_rd_en[0], transmit_out[0], mem_addr[0]}), 64'b0001);
      end
      shift_force[0] = 1'b0;

      // shift while LATCH is ignored; latch gap and data unaffected
      snap(0);
      start_frame(0);
      wait_lat(0, 48);
      for (int k = 0; k < 100 && transmit_out[0]; k++) @(negedge clk);
      shift_force[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("latch_shift", 64'({serial_out[0], mem_rd_en[0], transmit_out[0], done[0]}), 64'd0);
      end
      shift_force[0] = 1'b0;
      finish_frame(0, "latch_shift", 1'b0);
      check_deltas(0, "latch_shift", 1, {ram[0][0], ram[0][1]});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
